// File: rtl/muldiv_pkg.sv
// muldiv_pkg
//   Shared types and constants for the HI/LO multiply/divide sequencer.
//   - state_t : sequencer FSM encoding (IDLE/ITER/FIXUP)
//   - op_t    : latched operation (MULT/MULTU/DIV/DIVU)
//   - XLEN_DEF and the divide-by-zero result constants
//   Optional build macro used by the sequencer: MULDIV_EARLY_TERM_EN.
package muldiv_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ITER  = 2'b01,
    S_FIXUP = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } op_t;

  // Divide by zero: every quotient bit is this value (all ones); the
  // remainder is the dividend unchanged.
  localparam bit DIV0_QUOT_FILL = 1'b1;

  function automatic logic op_is_div(input op_t op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input op_t op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_iter_dp.sv
// muldiv_iter_dp
//   Iterative datapath for the multiply/divide sequencer. No FSM: the
//   sequencer pulses load once, then step once per iteration, and samples
//   res_hi/res_lo (already sign-corrected) in its FIXUP cycle.
// Ports
//   clk, rst_n     clock, async active-low reset
//   load           capture operands (magnitudes, signs, op)
//   step           perform one shift-add or restoring-subtract iteration
//   op             operation to capture on load
//   rs_val, rt_val operands A/dividend and B/divisor
//   res_hi, res_lo sign-corrected results (upper/remainder, lower/quotient)
//   mplier_empty   multiplier bits left after the current step are all zero
module muldiv_iter_dp
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  op_t             op,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  output logic [XLEN-1:0] res_hi,
  output logic [XLEN-1:0] res_lo,
  output logic            mplier_empty
);

  // Register roles:
  //   multiply: acc = product, mcand = shifted multiplicand, mq = multiplier
  //   divide:   acc[XLEN:0] = partial remainder, mcand[XLEN-1:0] = divisor,
  //             mq = dividend bits shifting out / quotient bits shifting in
  logic [2*XLEN-1:0] acc, acc_nxt;
  logic [2*XLEN-1:0] mcand, mcand_nxt;
  logic [XLEN-1:0]   mq, mq_nxt;
  op_t               op_q;
  logic              neg_res;
  logic              neg_rem;
  logic              div0;

  logic              rs_neg, rt_neg;
  logic [XLEN-1:0]   rs_mag, rt_mag;
  logic [XLEN:0]     shifted, diff;

  always_comb begin
    rs_neg = op_is_signed(op) & rs_val[XLEN-1];
    rt_neg = op_is_signed(op) & rt_val[XLEN-1];
    rs_mag = rs_neg ? (~rs_val + 1'b1) : rs_val;
    rt_mag = rt_neg ? (~rt_val + 1'b1) : rt_val;
  end

  always_comb begin
    acc_nxt   = acc;
    mcand_nxt = mcand;
    mq_nxt    = mq;
    shifted   = {acc[XLEN-1:0], mq[XLEN-1]};
    diff      = shifted - {1'b0, mcand[XLEN-1:0]};
    if (op_is_div(op_q)) begin
      // diff[XLEN] set means the trial subtract went negative: restore.
      if (!diff[XLEN]) begin
        acc_nxt = {{(XLEN-1){1'b0}}, diff};
        mq_nxt  = {mq[XLEN-2:0], 1'b1};
      end else begin
        acc_nxt = {{(XLEN-1){1'b0}}, shifted};
        mq_nxt  = {mq[XLEN-2:0], 1'b0};
      end
    end else begin
      // Multiplicand shifts left instead of the product shifting right, so
      // acc is the exact product as soon as the multiplier runs out of ones.
      acc_nxt   = acc + (mq[0] ? mcand : '0);
      mcand_nxt = {mcand[2*XLEN-2:0], 1'b0};
      mq_nxt    = {1'b0, mq[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      mcand   <= '0;
      mq      <= '0;
      op_q    <= MD_MULT;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
    end else if (load) begin
      acc     <= '0;
      op_q    <= op;
      neg_res <= rs_neg ^ rt_neg;
      neg_rem <= rs_neg;
      div0    <= op_is_div(op) && (rt_val == '0);
      if (op_is_div(op)) begin
        mcand <= {{XLEN{1'b0}}, rt_mag};
        mq    <= rs_mag;
      end else begin
        mcand <= {{XLEN{1'b0}}, rs_mag};
        mq    <= rt_mag;
      end
    end else if (step) begin
      acc   <= acc_nxt;
      mcand <= mcand_nxt;
      mq    <= mq_nxt;
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem;

  always_comb begin
    prod = neg_res ? (~acc + 1'b1) : acc;
    rem  = neg_rem ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
    if (div0)
      quot = {XLEN{DIV0_QUOT_FILL}};
    else
      quot = neg_res ? (~mq + 1'b1) : mq;
    if (op_is_div(op_q)) begin
      res_hi = rem;
      res_lo = quot;
    end else begin
      res_hi = prod[2*XLEN-1:XLEN];
      res_lo = prod[XLEN-1:0];
    end
  end

  assign mplier_empty = (mq[XLEN-1:1] == '0);

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Multi-cycle MULT/MULTU/DIV/DIVU sequencer and owner of the HI/LO
//   registers. Stalls the core while an operation is in flight and a
//   HI/LO access or a new multiply/divide is requested.
//   Build macro: MULDIV_EARLY_TERM_EN -- multiply leaves ITER once the
//   remaining multiplier bits are zero (results unchanged).
// Ports
//   clk, rst_n                 clock, async active-low reset
//   mult_en, div_en            issue MULT*/DIV* (mult_en wins if both)
//   unsigned_instr             1 = MULTU/DIVU
//   hi_write, lo_write         MTHI/MTLO (only when no mult/div issue)
//   hi_read, lo_read           MFHI/MFLO in decode
//   rs_val, rt_val             operands / MTHI-MTLO data
//   hi, lo                     architectural HI/LO
//   busy                       operation in flight
//   stall                      freeze PC and decode this cycle
//   done                       one-cycle pulse in FIXUP
//
// state | meaning
// IDLE  | no op in flight; accepts issue and MTHI/MTLO
// ITER  | one multiply/divide bit per cycle; HI/LO hold old values
// FIXUP | sign correction; HI/LO written at the end of this cycle
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mult_en,
  input  logic            div_en,
  input  logic            unsigned_instr,
  input  logic            hi_write,
  input  logic            lo_write,
  input  logic            hi_read,
  input  logic            lo_read,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            stall,
  output logic            done
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] COUNT_LAST = CW'(XLEN - 1);

`ifdef MULDIV_EARLY_TERM_EN
  localparam bit EARLY_TERM = 1'b1;
`else
  localparam bit EARLY_TERM = 1'b0;
`endif

  state_t          state;
  op_t             op_q;
  op_t             op_sel;
  logic [CW-1:0]   count;
  logic            load;
  logic            step;
  logic            iter_exit;
  logic [XLEN-1:0] res_hi, res_lo;
  logic            mplier_empty;

  always_comb begin
    op_sel = MD_MULT;
    if (mult_en)
      op_sel = unsigned_instr ? MD_MULTU : MD_MULT;
    else
      op_sel = unsigned_instr ? MD_DIVU : MD_DIV;
  end

  assign load = (state == S_IDLE) && (mult_en || div_en);
  assign step = (state == S_ITER);

  // EARLY_TERM is a build-time constant; with it clear only the count matters.
  assign iter_exit = (count == COUNT_LAST) ||
                     (EARLY_TERM && !op_is_div(op_q) && mplier_empty);

  assign stall = busy & (mult_en | div_en | hi_read | lo_read | hi_write | lo_write);

  muldiv_iter_dp #(.XLEN(XLEN)) u_dp (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (load),
    .step         (step),
    .op           (op_sel),
    .rs_val       (rs_val),
    .rt_val       (rt_val),
    .res_hi       (res_hi),
    .res_lo       (res_lo),
    .mplier_empty (mplier_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      op_q  <= MD_MULT;
      count <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (load) begin
            op_q  <= op_sel;
            count <= '0;
            busy  <= 1'b1;
            state <= S_ITER;
          end else begin
            if (hi_write) hi <= rs_val;
            if (lo_write) lo <= rs_val;
          end
        end
        S_ITER: begin
          count <= count + 1'b1;
          if (iter_exit) begin
            done  <= 1'b1;
            state <= S_FIXUP;
          end
        end
        S_FIXUP: begin
          hi    <= res_hi;
          lo    <= res_lo;
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
